// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: matrix size, debounce states and
// per-scan decode result, plus the snapshot decoder used at end of scan.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;

  typedef enum logic {IDLE, HELD} deb_state_t;
  typedef enum logic [1:0] {NONE, ONE, MULTI} decode_t;

  typedef struct packed {
    decode_t             kind;
    logic [CODE_W-1:0]   code;
  } scan_result_t;

  // Snapshot bit index is row*NUM_COLS + col, which is exactly the key code.
  function automatic scan_result_t decode_scan(input logic [NUM_ROWS*NUM_COLS-1:0] snap);
    scan_result_t res;
    int unsigned  hits;
    hits     = 0;
    res.code = '0;
    for (int i = 0; i < NUM_ROWS*NUM_COLS; i++) begin
      if (snap[i]) begin
        hits++;
        res.code = CODE_W'(i);
      end
    end
    if (hits == 0)
      res.kind = NONE;
    else if (hits == 1)
      res.kind = ONE;
    else
      res.kind = MULTI;
    return res;
  endfunction
endpackage

// File: rtl/keypad_scan_if.sv
// Peripheral-bus side of the keypad scanner: key events, digit history, clear.
interface keypad_scan_if;
  import keypad_pkg::*;

  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_held;
  logic [15:0]       digits;
  logic              clear;

  modport master (output key_valid, key_code, key_held, digits, input clear);
  modport slave  (input key_valid, key_code, key_held, digits, output clear);
endinterface

// File: rtl/keypad_debounce.sv
// Press/release debounce FSM, evaluated once per full keypad scan.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_done,
  input  decode_t           result,
  input  logic [CODE_W-1:0] code,
  output logic              accept,
  output logic              key_held
);
  localparam logic [3:0] K_TARGET = 4'(DEBOUNCE_SCANS);

  deb_state_t        state_reg;
  logic [3:0]        k_reg;
  logic [CODE_W-1:0] cand_reg;
  logic [3:0]        k_idle_next;

  // A ONE scan extends the run only if it repeats the current candidate.
  always_comb begin
    accept      = 1'b0;
    k_idle_next = 4'd1;
    if (state_reg == IDLE && result == ONE) begin
      k_idle_next = (code == cand_reg) ? k_reg + 4'd1 : 4'd1;
      accept      = scan_done && (k_idle_next == K_TARGET);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      k_reg     <= 4'd0;
      cand_reg  <= '0;
      key_held  <= 1'b0;
    end else if (scan_done) begin
      case (state_reg)
        IDLE: begin
          if (result == ONE) begin
            cand_reg <= code;
            if (accept) begin
              state_reg <= HELD;
              k_reg     <= 4'd0;
              key_held  <= 1'b1;
            end else begin
              k_reg <= k_idle_next;
            end
          end else begin
            k_reg <= 4'd0;
          end
        end
        HELD: begin
          if (result == NONE) begin
            if (k_reg + 4'd1 == K_TARGET) begin
              state_reg <= IDLE;
              k_reg     <= 4'd0;
              key_held  <= 1'b0;
            end else begin
              k_reg <= k_reg + 4'd1;
            end
          end else begin
            k_reg <= 4'd0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: column drive, row synchronizer, snapshot
// decode, debounced key events and a four-digit history for the display.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_INTERVAL  = 40000000/1000 - 1,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_sel,
  keypad_scan_if.master       bus
);
  localparam int CNT_W = $clog2(SCAN_INTERVAL + 1);
  localparam int SNAP_W = NUM_ROWS * NUM_COLS;

  logic [CNT_W-1:0]    dwell_reg;
  logic [1:0]          col_reg;
  logic [NUM_COLS-1:0] col_sel_reg;
  logic [NUM_ROWS-1:0] sync1_reg, sync2_reg;
  logic [SNAP_W-1:0]   snap_reg, snap_next;
  logic                sample, scan_done;
  scan_result_t        decoded;
  logic                accept, key_held;
  logic                key_valid_reg;
  logic [CODE_W-1:0]   key_code_reg;
  logic [15:0]         digits_reg;

  assign sample    = (dwell_reg == CNT_W'(SCAN_INTERVAL));
  assign scan_done = sample && (col_reg == 2'd3);

  // Synchronizer stores rows inverted so that 1 means "key down".
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_reg   <= '0;
      col_reg     <= 2'd0;
      col_sel_reg <= 4'b1110;
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      snap_reg    <= '0;
    end else begin
      sync1_reg <= ~row_in;
      sync2_reg <= sync1_reg;
      snap_reg  <= snap_next;
      if (sample) begin
        dwell_reg   <= '0;
        col_reg     <= col_reg + 2'd1;
        col_sel_reg <= ~(4'b0001 << (col_reg + 2'd1));
      end else begin
        dwell_reg <= dwell_reg + 1'b1;
      end
    end
  end

  // Column 3's rows are folded in combinationally so the decode sees the whole scan.
  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
    for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_col
      assign snap_next[gi*NUM_COLS + gc] =
        (sample && col_reg == 2'(gc)) ? sync2_reg[gi] : snap_reg[gi*NUM_COLS + gc];
    end
  end

  assign decoded = decode_scan(snap_next);

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .scan_done(scan_done),
    .result   (decoded.kind),
    .code     (decoded.code),
    .accept   (accept),
    .key_held (key_held)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid_reg <= 1'b0;
      key_code_reg  <= '0;
      digits_reg    <= '0;
    end else begin
      key_valid_reg <= accept;
      if (accept)
        key_code_reg <= decoded.code;
      if (bus.clear)
        digits_reg <= '0;
      else if (accept)
        digits_reg <= {digits_reg[11:0], decoded.code};
    end
  end

  assign col_sel       = col_sel_reg;
  assign bus.key_valid = key_valid_reg;
  assign bus.key_code  = key_code_reg;
  assign bus.key_held  = key_held;
  assign bus.digits    = digits_reg;
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model, scan-level reference model
// compared every cycle, plus hand-computed scenario checks.
module tb_keypad_scan;
  import keypad_pkg::*;

  localparam int SI    = 3;
  localparam int DS    = 2;
  localparam int DWELL = SI + 1;
  localparam int P     = 4 * DWELL;
  localparam int SETTLE = (DS + 1) * P + 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_sel;
  logic [15:0] pressed = 16'h0;

  keypad_scan_if bus();

  keypad_scan #(.SCAN_INTERVAL(SI), .DEBOUNCE_SCANS(DS)) dut (
    .clk    (clk),
    .reset  (reset),
    .row_in (row_in),
    .col_sel(col_sel),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Ideal switch matrix: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_sel[c] && pressed[r*4+c]) row_in[r] = 1'b0;
  end

  int errors = 0;
  int checks = 0;
  int valid_count = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // -1 = no key, -2 = several keys, otherwise the single key's code.
  function automatic int classify(logic [15:0] s);
    int cnt;
    int idx;
    cnt = 0;
    idx = 0;
    for (int i = 0; i < 16; i++) if (s[i]) begin cnt++; idx = i; end
    if (cnt == 0) return -1;
    if (cnt > 1) return -2;
    return idx;
  endfunction

  // Reference model: what the keypad looked like to the scanner, scan by scan.
  int          n_edges;
  int          cur_col;
  bit          same;
  bit          started = 1'b0;
  logic [15:0] h0, h1, h2, seen;
  int          hist[$];
  bit          m_held;
  logic        m_valid;
  logic [3:0]  m_code;
  logic [15:0] m_digits;
  logic [3:0]  m_colsel;

  always @(posedge clk) begin
    if (reset) begin
      n_edges = 0;
      h0 = '0; h1 = '0; h2 = '0; seen = '0;
      hist.delete();
      m_held = 0; m_valid = 0; m_code = '0; m_digits = '0;
      m_colsel = 4'b1110;
    end else begin
      h2 = h1; h1 = h0; h0 = pressed;
      m_valid = 1'b0;
      if (n_edges % DWELL == DWELL - 1) begin
        cur_col = (n_edges / DWELL) % 4;
        for (int r = 0; r < 4; r++) seen[r*4+cur_col] = h2[r*4+cur_col];
        if (cur_col == 3) begin
          hist.push_back(classify(seen));
          if (hist.size() > DS) void'(hist.pop_front());
          if (hist.size() == DS) begin
            same = 1;
            for (int i = 1; i < DS; i++) if (hist[i] != hist[0]) same = 0;
            if (same && !m_held && hist[0] >= 0) begin
              m_valid  = 1'b1;
              m_code   = 4'(hist[0]);
              m_digits = {m_digits[11:0], 4'(hist[0])};
              m_held   = 1;
              hist.delete();
            end else if (same && m_held && hist[0] == -1) begin
              m_held = 0;
              hist.delete();
            end
          end
        end
      end
      if (bus.clear) m_digits = '0;
      n_edges++;
      m_colsel = ~(4'b0001 << ((n_edges / DWELL) % 4));
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("col_sel",   32'(col_sel),       32'(m_colsel));
      check("key_valid", 32'(bus.key_valid), 32'(m_valid));
      check("key_code",  32'(bus.key_code),  32'(m_code));
      check("key_held",  32'(bus.key_held),  32'(m_held));
      check("digits",    32'(bus.digits),    32'(m_digits));
      if (bus.key_valid) begin
        valid_count++;
        $display("key event: code=%h digits=%h t=%0t", bus.key_code, bus.digits, $time);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [15:0] m, input int n);
    pressed = m;
    tick(n);
  endtask

  int          v0;
  int          k1;
  int          nb;
  logic [15:0] m;

  initial begin
    bus.clear = 1'b0;
    tick(3);
    reset = 1'b0;

    // Reset state and column rotation
    check("rst_col0", 32'(col_sel), 32'h0000000E);
    check("rst_valid", 32'(bus.key_valid), 32'h0);
    check("rst_held", 32'(bus.key_held), 32'h0);
    check("rst_code", 32'(bus.key_code), 32'h0);
    check("rst_digits", 32'(bus.digits), 32'h0);
    tick(4);  check("rst_col1", 32'(col_sel), 32'h0000000D);
    tick(4);  check("rst_col2", 32'(col_sel), 32'h0000000B);
    tick(4);  check("rst_col3", 32'(col_sel), 32'h00000007);
    tick(4);  check("rst_col4", 32'(col_sel), 32'h0000000E);

    // Single press: row 2, column 1
    v0 = valid_count;
    hold(16'h1 << 9, SETTLE);
    check("single_events", 32'(valid_count - v0), 32'd1);
    check("single_code", 32'(bus.key_code), 32'h9);
    check("single_digits", 32'(bus.digits), 32'h0009);
    check("single_held", 32'(bus.key_held), 32'h1);
    hold(16'h0, SETTLE);
    check("single_release", 32'(bus.key_held), 32'h0);

    // Digit history and clear
    for (int k = 1; k <= 5; k++) begin
      hold(16'h1 << k, SETTLE);
      hold(16'h0, SETTLE);
    end
    check("history_digits", 32'(bus.digits), 32'h2345);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    check("clear_digits", 32'(bus.digits), 32'h0);
    check("clear_code", 32'(bus.key_code), 32'h5);

    // Bounce: toggle every 5 cycles for 40 cycles, then steady
    v0 = valid_count;
    for (int b = 0; b < 4; b++) begin
      hold(16'h1 << 10, 5);
      hold(16'h0, 5);
    end
    hold(16'h1 << 10, SETTLE);
    check("bounce_events", 32'(valid_count - v0), 32'd1);
    check("bounce_code", 32'(bus.key_code), 32'hA);
    hold(16'h0, SETTLE);

    // Two keys together never qualify
    v0 = valid_count;
    hold(16'h8001, SETTLE);
    check("multi_events", 32'(valid_count - v0), 32'd0);
    check("multi_held", 32'(bus.key_held), 32'h0);
    hold(16'h0, SETTLE);

    // Second key while held: no event until released and pressed again
    v0 = valid_count;
    hold(16'h0008, SETTLE);
    hold(16'h0088, SETTLE);
    check("second_events", 32'(valid_count - v0), 32'd1);
    check("second_code", 32'(bus.key_code), 32'h3);
    hold(16'h0, SETTLE);
    hold(16'h0080, SETTLE);
    check("second_events2", 32'(valid_count - v0), 32'd2);
    check("second_code2", 32'(bus.key_code), 32'h7);
    hold(16'h0, SETTLE);

    // Reset while held; key still down is re-accepted afterwards
    hold(16'h0020, SETTLE);
    check("pre_reset_held", 32'(bus.key_held), 32'h1);
    reset = 1'b1;
    tick(1);
    check("reset_held", 32'(bus.key_held), 32'h0);
    check("reset_digits", 32'(bus.digits), 32'h0);
    reset = 1'b0;
    v0 = valid_count;
    tick(SETTLE);
    check("reaccept_events", 32'(valid_count - v0), 32'd1);
    check("reaccept_code", 32'(bus.key_code), 32'h5);
    check("reaccept_held", 32'(bus.key_held), 32'h1);
    hold(16'h0, SETTLE);

    // Randomized presses with bounce, occasional second key and clear
    for (int i = 0; i < 20; i++) begin
      k1 = int'($urandom_range(0, 15));
      m = 16'h1 << k1;
      if ($urandom_range(0, 4) == 0) m = m | (16'h1 << $urandom_range(0, 15));
      nb = int'($urandom_range(0, 3));
      for (int b = 0; b < nb; b++) begin
        hold(m, int'($urandom_range(1, 7)));
        hold(16'h0, int'($urandom_range(1, 7)));
      end
      hold(m, int'($urandom_range(P, 4 * P)));
      if ($urandom_range(0, 3) == 0) begin
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
      end
      hold(16'h0, int'($urandom_range(P, 4 * P)));
    end
    tick(SETTLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
